flop_pipe: RTL and testbench
============================

Name: flop_pipe

Overview:
- Parametrised successor to the plain resettable 32-bit flop.
- Provides an elastic pipeline of DEPTH register stages with a valid/ready handshake, flush, a per-instance reset value and an occupancy count.
- Used as the inter-stage register for the pipelined RISC-V core (IF/ID, ID/EX, ...) and as a generic delay line where back-pressure is needed.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 1, number of register stages; legal range 1..8.
- RESET_VAL, '0 (WIDTH bits), value every data register takes on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all stage contents; acts at the next rising edge.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  WIDTH  payload.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  WIDTH  payload of the last stage.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Stages are indexed 0 (input side) to DEPTH-1 (output side). Each stage holds valid_i and data_i.
- Reset (synchronous, priority over everything): all valid_i=0, all data_i=RESET_VAL. After the edge: out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 (unless flush is high).
- Advance rule: adv_{DEPTH-1} = !valid_{DEPTH-1} | out_ready; adv_i = !valid_i | adv_{i+1}. This is a combinational ready chain, so bubbles collapse.
- in_ready = adv_0 & !flush.
- On a clock edge, for each stage with adv_i=1:
  - data_i and valid_i load from stage i-1 (stage 0 loads from in_data / in_valid&in_ready).
  - Data loads only when the source is valid; otherwise data_i holds and valid_i clears.
  - A stage with adv_i=0 holds both data_i and valid_i.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Latency: DEPTH cycles from input transfer to out_valid with no back-pressure. Throughput is 1 item/cycle sustained.
- out_data is driven directly from data_{DEPTH-1}, with no output mux. It keeps its last value while out_valid=0.
- Flush (reset inactive):
  - in_ready=0 in that cycle, so input is dropped.
  - All valid_i=0 at the edge; data registers hold.
  - A simultaneous output transfer still counts as consumed by the downstream.
- Full: all valid and out_ready=0 -> in_ready=0, contents frozen. With out_ready=1 while full, in_ready=1 in the same cycle and the pipeline shifts without a bubble.
- occupancy: registered count, reset 0.
  - +1 on input transfer, -1 on output transfer, unchanged when both occur.
  - Forced to 0 on flush or reset.
  - Must always equal the popcount of valid_i; never exceeds DEPTH.
- Reset mid-stream: in-flight items are lost. No output transfer may be asserted in the cycle after reset.
- DEPTH outside 1..8 is a fatal elaboration error.

Decomposition:
- Package flop_pipe_pkg holds:
  - the localparam function occ_width(depth) = $clog2(depth+1);
  - MAX_DEPTH=8.
- Sub-module flop_pipe_stage (one valid+data register with adv, src_valid, src_data, flush, reset, RESET_VAL). flop_pipe instantiates DEPTH of them in a generate loop and builds the adv chain and occupancy counter.

Test Plan:
- Reset for 2 cycles, DEPTH=1, WIDTH=32, RESET_VAL=32'hDEADBEEF -> out_valid=0, out_data=32'hDEADBEEF, occupancy=0, in_ready=1.
- DEPTH=3, out_ready=1, stream 32'h4,32'h5,32'h6 on consecutive cycles -> out_data 32'h4 valid exactly 3 cycles after its input edge, then 5 and 6 back-to-back, occupancy peaks at 3.
- DEPTH=3, out_ready=0, push 4 items 1..4 -> items 1..3 accepted, in_ready=0 on the 4th, occupancy=3. Raise out_ready for one cycle -> 1 exits, 4 accepted the same cycle, occupancy stays 3.
- DEPTH=4, push A, idle 2 cycles, push B, with out_ready=0 -> bubbles collapse: A in stage 3, B in stage 2, occupancy=2.
- DEPTH=3 holding 2 items, assert flush with in_valid=1 and out_ready=1 -> in_ready=0 that cycle; next cycle out_valid=0, occupancy=0. Input 32'h7 afterwards emerges 3 cycles later.
- Assert reset mid-stream with occupancy=2 -> next cycle occupancy=0, out_valid=0, out_data=RESET_VAL. Random valid/ready soak checks that occupancy equals the popcount of valid_i and that data order is preserved.

Source files
------------

// File: rtl/flop_pipe_pkg.sv
// flop_pipe_pkg: shared constants and helpers for the elastic pipeline register
package flop_pipe_pkg;
  localparam int MAX_DEPTH = 8;
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/flop_pipe_stage.sv
// flop_pipe_stage: one valid+data register of the elastic pipeline
module flop_pipe_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             adv,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else begin
      valid <= !flush && (adv ? src_valid : valid);
      if (adv && src_valid && !flush) data <= src_data;
    end
  end
endmodule

// File: rtl/flop_pipe.sv
// flop_pipe: DEPTH-stage elastic pipeline with valid/ready, flush and occupancy count
module flop_pipe
  import flop_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [occ_width(DEPTH)-1:0]     occupancy
);
  localparam int OW = occ_width(DEPTH);
  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $fatal(1, "flop_pipe: DEPTH must be within 1..%0d", MAX_DEPTH);
  end
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data [DEPTH];
  logic             in_xfer;
  logic             out_xfer;
  always_comb begin
    logic a;
    a   = out_ready;
    adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a      = a | ~valid[i];
      adv[i] = a;
    end
  end
  assign in_ready  = adv[0] & ~flush;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             sv;
    logic [WIDTH-1:0] sd;
    if (i == 0) begin : g_head
      assign sv = in_xfer;
      assign sd = in_data;
    end else begin : g_body
      assign sv = valid[i-1];
      assign sd = data[i-1];
    end
    flop_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .adv       (adv[i]),
      .src_valid (sv),
      .src_data  (sd),
      .valid     (valid[i]),
      .data      (data[i])
    );
  end
  always_ff @(posedge clk) begin
    if (reset || flush) occupancy <= '0;
    else occupancy <= occupancy + OW'(in_xfer) - OW'(out_xfer);
  end
endmodule

// File: tb/tb_flop_pipe.sv
// tb_flop_pipe: table, directed and random checks of three flop_pipe instances against a queue model
module tb_flop_pipe;
  localparam logic [31:0] RV1 = 32'hDEADBEEF;
  localparam logic [31:0] RV3 = 32'hA5A50003;
  localparam logic [31:0] RV4 = 32'h00000404;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        ir1, ir3, ir4, ov1, ov3, ov4;
  logic [31:0] od1, od3, od4;
  logic [0:0]  oc1;
  logic [1:0]  oc3;
  logic [2:0]  oc4;
  flop_pipe #(.WIDTH(32), .DEPTH(1), .RESET_VAL(RV1)) d1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(oc1));
  flop_pipe #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV3)) d3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
    .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .occupancy(oc3));
  flop_pipe #(.WIDTH(32), .DEPTH(4), .RESET_VAL(RV4)) d4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .occupancy(oc4));
  int checks = 0;
  int errors = 0;
  int          dep [3] = '{1, 3, 4};
  logic [31:0] rv [3];
  int          n [3];
  int          pos [3][8];
  logic [31:0] dat [3][8];
  logic [31:0] last [3];
  typedef struct {
    bit          r, f, v;
    logic [31:0] d;
    bit          o;
    bit          eir, eov;
    logic [31:0] eod;
    int          eoc;
  } vec_t;
  vec_t tv [10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input bit r, input bit f, input bit v, input logic [31:0] d, input bit o);
    reset = r; flush = f; in_valid = v; in_data = d; out_ready = o;
  endtask
  function automatic bit m_ir(input int k);
    return !flush && (n[k] < dep[k] || out_ready);
  endfunction
  function automatic bit m_ov(input int k);
    return n[k] > 0 && pos[k][0] == dep[k] - 1;
  endfunction
  task automatic model_step(input int k);
    int  d, np;
    bit  rdy;
    d   = dep[k];
    rdy = m_ir(k);
    if (reset) begin
      n[k] = 0;
      last[k] = rv[k];
    end else if (flush) begin
      n[k] = 0;
    end else begin
      for (int j = 0; j < n[k]; j++) begin
        np = pos[k][j] + (((j < d - 1 - pos[k][j]) || out_ready) ? 1 : 0);
        if (np == d - 1 && np != pos[k][j]) last[k] = dat[k][j];
        pos[k][j] = np;
      end
      if (n[k] > 0 && pos[k][0] == d) begin
        for (int j = 0; j < n[k] - 1; j++) begin
          pos[k][j] = pos[k][j+1];
          dat[k][j] = dat[k][j+1];
        end
        n[k]--;
      end
      if (in_valid && rdy) begin
        pos[k][n[k]] = 0;
        dat[k][n[k]] = in_data;
        n[k]++;
        if (d == 1) last[k] = in_data;
      end
    end
  endtask
  task automatic cyc();
    #1;
    chk("d1 in_ready", 32'(ir1), 32'(m_ir(0)));
    chk("d3 in_ready", 32'(ir3), 32'(m_ir(1)));
    chk("d4 in_ready", 32'(ir4), 32'(m_ir(2)));
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #1;
    chk("d1 out_valid", 32'(ov1), 32'(m_ov(0)));
    chk("d3 out_valid", 32'(ov3), 32'(m_ov(1)));
    chk("d4 out_valid", 32'(ov4), 32'(m_ov(2)));
    chk("d1 out_data", od1, last[0]);
    chk("d3 out_data", od3, last[1]);
    chk("d4 out_data", od4, last[2]);
    chk("d1 occupancy", 32'(oc1), 32'(n[0]));
    chk("d3 occupancy", 32'(oc3), 32'(n[1]));
    chk("d4 occupancy", 32'(oc4), 32'(n[2]));
    chk("d4 occupancy bound", 32'(oc4 <= 3'd4), 32'd1);
  endtask
  initial begin
    rv = '{RV1, RV3, RV4};
    tv[0] = '{1, 0, 0, 32'h0,  0, 1, 0, RV1,      0};
    tv[1] = '{1, 0, 0, 32'h0,  0, 1, 0, RV1,      0};
    tv[2] = '{0, 0, 1, 32'h11, 0, 0, 1, 32'h11,   1};
    tv[3] = '{0, 0, 1, 32'h22, 0, 0, 1, 32'h11,   1};
    tv[4] = '{0, 0, 1, 32'h22, 1, 1, 1, 32'h22,   1};
    tv[5] = '{0, 0, 0, 32'h0,  1, 1, 0, 32'h22,   0};
    tv[6] = '{0, 1, 1, 32'h33, 0, 0, 0, 32'h22,   0};
    tv[7] = '{0, 0, 1, 32'h33, 0, 0, 1, 32'h33,   1};
    tv[8] = '{0, 1, 0, 32'h0,  0, 0, 0, 32'h33,   0};
    tv[9] = '{1, 0, 0, 32'h0,  0, 1, 0, RV1,      0};
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n[k] = 0;
      last[k] = rv[k];
    end
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].r, tv[i].f, tv[i].v, tv[i].d, tv[i].o);
      cyc();
      chk($sformatf("tbl%0d in_ready", i), 32'(ir1), 32'(tv[i].eir));
      chk($sformatf("tbl%0d out_valid", i), 32'(ov1), 32'(tv[i].eov));
      chk($sformatf("tbl%0d out_data", i), od1, tv[i].eod);
      chk($sformatf("tbl%0d occupancy", i), 32'(oc1), 32'(tv[i].eoc));
    end
    drive(1, 0, 0, 0, 1); cyc(); cyc();
    drive(0, 0, 1, 32'h4, 1); cyc(); chk("stream ov e1", 32'(ov3), 0);
    drive(0, 0, 1, 32'h5, 1); cyc(); chk("stream ov e2", 32'(ov3), 0);
    drive(0, 0, 1, 32'h6, 1); cyc();
    chk("stream ov e3", 32'(ov3), 1); chk("stream od e3", od3, 32'h4); chk("stream occ peak", 32'(oc3), 3);
    drive(0, 0, 0, 32'h0, 1); cyc(); chk("stream od e4", od3, 32'h5);
    cyc(); chk("stream od e5", od3, 32'h6);
    cyc(); chk("stream ov e6", 32'(ov3), 0); chk("stream occ e6", 32'(oc3), 0);
    drive(1, 0, 0, 0, 0); cyc();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 1, 32'(i), 0); cyc();
    end
    drive(0, 0, 1, 32'h4, 0); #1 chk("full in_ready", 32'(ir3), 0);
    cyc(); chk("full occ", 32'(oc3), 3); chk("full od", od3, 32'h1);
    drive(0, 0, 1, 32'h4, 1); #1 chk("full drain in_ready", 32'(ir3), 1);
    cyc(); chk("shift od", od3, 32'h2); chk("shift occ", 32'(oc3), 3);
    drive(0, 0, 0, 32'h0, 1); cyc(); cyc(); chk("drain order", od3, 32'h4);
    drive(1, 0, 0, 0, 0); cyc();
    drive(0, 0, 1, 32'hA, 0); cyc();
    drive(0, 0, 0, 32'h0, 0); cyc(); cyc();
    drive(0, 0, 1, 32'hB, 0); cyc();
    drive(0, 0, 0, 32'h0, 0); cyc(); cyc();
    chk("bubble occ", 32'(oc4), 2); chk("bubble od", od4, 32'hA);
    drive(0, 0, 0, 32'h0, 1); cyc();
    chk("bubble next od", od4, 32'hB); chk("bubble next ov", 32'(ov4), 1); chk("bubble next occ", 32'(oc4), 1);
    drive(1, 0, 0, 0, 0); cyc();
    drive(0, 0, 1, 32'h21, 0); cyc();
    drive(0, 0, 1, 32'h22, 0); cyc();
    drive(0, 1, 1, 32'h99, 1); #1 chk("flush in_ready", 32'(ir3), 0);
    cyc(); chk("flush ov", 32'(ov3), 0); chk("flush occ", 32'(oc3), 0); chk("flush od", od3, RV3);
    drive(0, 0, 1, 32'h7, 1); cyc();
    drive(0, 0, 0, 32'h0, 1); cyc(); chk("post flush ov e2", 32'(ov3), 0);
    cyc(); chk("post flush ov e3", 32'(ov3), 1); chk("post flush od", od3, 32'h7);
    drive(1, 0, 0, 0, 0); cyc();
    drive(0, 0, 1, 32'h31, 0); cyc();
    drive(0, 0, 1, 32'h32, 0); cyc();
    chk("pre reset occ", 32'(oc3), 2);
    drive(1, 0, 1, 32'h33, 1); cyc();
    chk("mid reset occ", 32'(oc3), 0); chk("mid reset ov", 32'(ov3), 0); chk("mid reset od", od3, RV3);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            $urandom, $urandom_range(0, 2) != 0);
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
